mem_arbiter2: RTL

Two-master arbiter sharing one synchronous single-port 16-bit RAM between the processor memory port (master 0) and a second requester such as a host loader or DMA engine (master 1). Round-robin arbitration with registered grants, bounded ownership (hold limit), and per-master read-valid return. Sits between the masters and the RAM; the RAM registers its address/data/write inputs internally and returns read data one cycle later.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter2_if.sv | 42 ++++
 rtl/arb_hold_counter.sv | 36 +++
 rtl/mem_arbiter2.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter.
// Holds the FSM state encoding, master indices and default widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int AW_DEF       = 16;
    localparam int DW_DEF       = 16;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Bus bundle between two masters, the arbiter and a single-port RAM.
// Ports: req/we/addr/wdata and gnt/rvalid per master, shared rdata,
// and the RAM side mem_addr/mem_wdata/mem_we/mem_q.
// slave = arbiter view, master = masters + RAM view.
interface mem_arbiter2_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1,
        input  wdata0, wdata1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1,
        output wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/arb_hold_counter.sv
// Ownership length counter for the arbiter.
// Ports: Clock, Resetn (sync, active-low), i_clr (new owner),
// i_en (owner cycle), o_at_limit (current cycle is the last allowed).
module arb_hold_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_at_limit
);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // r_cnt counts completed owner cycles, so the MAX_HOLD-th granted
    // cycle is the one where r_cnt == MAX_HOLD-1; saturation keeps a
    // long uncontended owner at the limit once contention appears.
    assign o_at_limit = (r_cnt == CNT_LAST) || (r_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter sharing one synchronous single-port RAM.
// Ports: Clock, Resetn (sync, active-low), bus (slave modport) with
// per-master req/we/addr/wdata/gnt/rvalid, rdata and the RAM mem_* side.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           Clock,
    input  logic           Resetn,
    mem_arbiter2_if.slave  bus
);
    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic       w_at_limit;
    logic       w_clr;
    logic       w_en;
    logic       w_gnt0;
    logic       w_gnt1;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_next = (r_last == M1) ? ARB_OWN0 : ARB_OWN1;
                end else if (bus.req0) begin
                    w_next = ARB_OWN0;
                end else if (bus.req1) begin
                    w_next = ARB_OWN1;
                end else begin
                    w_next = ARB_IDLE;
                end
            end
            ARB_OWN0: begin
                if (bus.req0) begin
                    if (bus.req1 && w_at_limit) begin
                        w_next = ARB_OWN1;
                    end
                end else if (bus.req1) begin
                    w_next = ARB_OWN1;
                end else begin
                    w_next = ARB_IDLE;
                end
            end
            ARB_OWN1: begin
                if (bus.req1) begin
                    if (bus.req0 && w_at_limit) begin
                        w_next = ARB_OWN0;
                    end
                end else if (bus.req0) begin
                    w_next = ARB_OWN0;
                end else begin
                    w_next = ARB_IDLE;
                end
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        unique case (r_state)
            ARB_OWN0: begin
                w_gnt0        = 1'b1;
                bus.mem_addr  = bus.addr0;
                bus.mem_wdata = bus.wdata0;
                bus.mem_we    = bus.req0 & bus.we0;
            end
            ARB_OWN1: begin
                w_gnt1        = 1'b1;
                bus.mem_addr  = bus.addr1;
                bus.mem_wdata = bus.wdata1;
                bus.mem_we    = bus.req1 & bus.we1;
            end
            default: ;
        endcase
    end

    // Any move into an owner state (from idle or a handover) is an entry.
    assign w_clr = (w_next != ARB_IDLE) && (w_next != r_state);
    assign w_en  = (r_state != ARB_IDLE);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .i_clr      (w_clr),
        .i_en       (w_en),
        .o_at_limit (w_at_limit)
    );

    // rvalid follows the issuing master, not the current owner.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_last    <= M1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            if (w_clr) begin
                r_last <= (w_next == ARB_OWN1) ? M1 : M0;
            end
            r_rvalid0 <= w_gnt0 & bus.req0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & bus.req1 & ~bus.we1;
        end
    end

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = bus.mem_q;

endmodule
